// File: rtl/line_streamer.sv
// Line streamer: fetches a line's {len, start} pointer entry, then streams its character
// pairs over valid/ready through a 2-entry buffer. Optional macro LINE_STREAMER_REVERSE_EN.
module line_streamer #(
  parameter int ADDR_W = 8,
  parameter int CHAR_W = 8,
  parameter int LEN_W  = 8,
  parameter int LINE_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [LINE_W-1:0]       line,
  input  logic                    swap,
`ifdef LINE_STREAMER_REVERSE_EN
  input  logic                    reverse,
`endif
  input  logic                    abort,
  output logic [LINE_W-1:0]       ptr_addr,
  input  logic [LEN_W+ADDR_W-1:0] ptr_dout,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [2*CHAR_W-1:0]     mem_dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHAR_W-1:0]       out_lhs,
  output logic [CHAR_W-1:0]       out_rhs,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {S_IDLE, S_PTR, S_LOAD, S_STREAM, S_FIN} state_e;

  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);
  localparam logic [LEN_W-1:0]  ONE_L = LEN_W'(1);

  state_e                state_q, state_d;
  logic [LINE_W-1:0]     ptr_addr_q, ptr_addr_d;
  logic                  swap_q, swap_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [LEN_W-1:0]      rem_q, rem_d;
  logic                  infl_q, infl_d;
  logic                  infl_last_q, infl_last_d;
  logic [2*CHAR_W:0]     fifo_q [2];
  logic                  wr_q, wr_d, rd_q, rd_d;
  logic [1:0]            cnt_q, cnt_d;
`ifdef LINE_STREAMER_REVERSE_EN
  logic                  rev_q, rev_d;
`endif

  logic [LEN_W-1:0]      ptr_len;
  logic [ADDR_W-1:0]     ptr_base;
  logic                  pop, push, flush, room;
  logic [1:0]            occ_after;
  logic [2*CHAR_W:0]     head;

  assign ptr_len   = ptr_dout[LEN_W+ADDR_W-1 -: LEN_W];
  assign ptr_base  = ptr_dout[ADDR_W-1:0];
  assign pop       = (cnt_q != 2'd0) && out_ready;
  assign occ_after = cnt_q - {1'b0, pop};
  // The read issued now lands in the buffer next cycle, so only one read is ever in flight.
  assign room      = ({1'b0, occ_after} + {2'b00, infl_q}) < 3'd2;

  always_comb begin
    state_d     = state_q;
    ptr_addr_d  = ptr_addr_q;
    swap_d      = swap_q;
    mem_addr_d  = mem_addr_q;
    rem_d       = rem_q;
    infl_d      = 1'b0;
    infl_last_d = 1'b0;
    flush       = 1'b0;
`ifdef LINE_STREAMER_REVERSE_EN
    rev_d       = rev_q;
`endif
    case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_PTR;
        ptr_addr_d = line;
        swap_d     = swap;
`ifdef LINE_STREAMER_REVERSE_EN
        rev_d      = reverse;
`endif
      end
      S_PTR: state_d = S_LOAD;
      S_LOAD: begin
        rem_d = ptr_len;
        if (ptr_len == '0) begin
          state_d = S_FIN;
        end else begin
          state_d    = S_STREAM;
          mem_addr_d = ptr_base;
`ifdef LINE_STREAMER_REVERSE_EN
          if (rev_q) mem_addr_d = ptr_base + ADDR_W'(ptr_len) - ONE_A;
`endif
        end
      end
      S_STREAM: begin
        if (rem_q != '0 && room) begin
          mem_addr_d  = mem_addr_q + ONE_A;
`ifdef LINE_STREAMER_REVERSE_EN
          if (rev_q) mem_addr_d = mem_addr_q - ONE_A;
`endif
          rem_d       = rem_q - ONE_L;
          infl_d      = 1'b1;
          infl_last_d = (rem_q == ONE_L);
        end else if (rem_q == '0 && !infl_q && occ_after == 2'd0) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d    = S_IDLE;
        mem_addr_d = '1;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      flush       = 1'b1;
      state_d     = S_IDLE;
      mem_addr_d  = '1;
      rem_d       = '0;
      infl_d      = 1'b0;
      infl_last_d = 1'b0;
    end
  end

  assign push  = infl_q && !flush;
  assign cnt_d = flush ? 2'd0 : cnt_q + {1'b0, push} - {1'b0, pop};
  assign wr_d  = flush ? 1'b0 : wr_q ^ push;
  assign rd_d  = flush ? 1'b0 : rd_q ^ pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_addr_q  <= '0;
      swap_q      <= 1'b0;
      mem_addr_q  <= '1;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      cnt_q       <= 2'd0;
      for (int unsigned i = 0; i < 2; i++) fifo_q[i] <= '0;
`ifdef LINE_STREAMER_REVERSE_EN
      rev_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_addr_q  <= ptr_addr_d;
      swap_q      <= swap_d;
      mem_addr_q  <= mem_addr_d;
      rem_q       <= rem_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      if (push) fifo_q[wr_q] <= {infl_last_q, mem_dout};
`ifdef LINE_STREAMER_REVERSE_EN
      rev_q       <= rev_d;
`endif
    end
  end

  assign head      = fifo_q[rd_q];
  assign ptr_addr  = ptr_addr_q;
  assign mem_addr  = mem_addr_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_last  = out_valid && head[2*CHAR_W];
  assign out_lhs   = swap_q ? head[CHAR_W-1:0] : head[2*CHAR_W-1:CHAR_W];
  assign out_rhs   = swap_q ? head[2*CHAR_W-1:CHAR_W] : head[CHAR_W-1:0];
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FIN);

endmodule

// File: tb/tb_line_streamer.sv
// Directed bench for line_streamer: pointer table and char-pair ROM are 1-cycle synchronous models.
module tb_line_streamer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, swap = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [7:0]  line = '0;
  logic [7:0]  ptr_addr, mem_addr, out_lhs, out_rhs;
  logic [15:0] ptr_dout = '0, mem_dout = '0;
  logic        out_valid, out_last, busy, done;
  logic [15:0] ptab [256];
  logic [15:0] cmem [256];
  int          n_checks = 0;
  int          n_err = 0;

  line_streamer #(.ADDR_W(8), .CHAR_W(8), .LEN_W(8), .LINE_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .line(line), .swap(swap),
`ifdef LINE_STREAMER_REVERSE_EN
    .reverse(1'b0),
`endif
    .abort(abort), .ptr_addr(ptr_addr), .ptr_dout(ptr_dout),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .out_valid(out_valid),
    .out_ready(out_ready), .out_lhs(out_lhs), .out_rhs(out_rhs),
    .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ptr_dout <= ptab[ptr_addr];
    mem_dout <= cmem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat();
    return {14'd0, out_valid, out_last, out_lhs, out_rhs};
  endfunction

  function automatic logic [31:0] bx(input logic l, input logic [7:0] a, input logic [7:0] b);
    return {14'd0, 1'b1, l, a, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start sampled in cycle 0; returns in cycle 1.
  task automatic launch(input logic [7:0] l, input logic s);
    line = l; swap = s; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin ptab[i] = '0; cmem[i] = 16'hDEAD; end
    ptab[1] = {8'd3, 8'h10};
    ptab[2] = {8'd0, 8'h20};
    ptab[3] = {8'd3, 8'hFE};
    cmem[8'h10] = 16'h4161; cmem[8'h11] = 16'h4262; cmem[8'h12] = 16'h4363;
    cmem[8'hFE] = 16'h5171; cmem[8'hFF] = 16'h5272; cmem[8'h00] = 16'h5373;

    #1 rst = 1'b0;
    #2;
    chk("rst_ptr_addr", ptr_addr, 0);
    chk("rst_mem_addr", mem_addr, 8'hFF);
    chk("rst_beat", beat(), 0);
    chk("rst_busy_done", {busy, done}, 0);
    @(posedge clk); #1 rst = 1'b1;

    // nominal line, full throughput
    out_ready = 1'b1;
    launch(8'd1, 1'b0);
    chk("t1_ptr_addr", ptr_addr, 8'd1);
    chk("t1_busy_c1", busy, 1);
    tick(); tick();
    chk("t1_mem_addr_c3", mem_addr, 8'h10);
    tick();
    chk("t1_valid_c4", out_valid, 0);
    tick(); chk("t1_beat_c5", beat(), bx(1'b0, 8'h41, 8'h61));
    tick(); chk("t1_beat_c6", beat(), bx(1'b0, 8'h42, 8'h62));
    tick(); chk("t1_beat_c7", beat(), bx(1'b1, 8'h43, 8'h63));
    tick(); chk("t1_done_c8", {done, out_valid}, 2'b10);
    tick(); chk("t1_idle_c9", {busy, done}, 0);

    // swapped output
    launch(8'd1, 1'b1);
    tick(); tick(); tick(); tick();
    chk("t2_beat_c5", beat(), bx(1'b0, 8'h61, 8'h41));
    tick(); chk("t2_beat_c6", beat(), bx(1'b0, 8'h62, 8'h42));
    tick(); chk("t2_beat_c7", beat(), bx(1'b1, 8'h63, 8'h43));
    tick(); chk("t2_done_c8", done, 1);
    tick();

    // backpressure: ready 1,0,0,1,0,1 from cycle 5
    launch(8'd1, 1'b0);
    tick(); tick(); tick();
    tick(); out_ready = 1'b1; chk("t3_beat_c5", beat(), bx(1'b0, 8'h41, 8'h61));
    tick(); out_ready = 1'b0; chk("t3_beat_c6", beat(), bx(1'b0, 8'h42, 8'h62));
    tick(); out_ready = 1'b0; chk("t3_hold_c7", beat(), bx(1'b0, 8'h42, 8'h62));
    tick(); out_ready = 1'b1; chk("t3_hold_c8", beat(), bx(1'b0, 8'h42, 8'h62));
    tick(); out_ready = 1'b0; chk("t3_beat_c9", beat(), bx(1'b1, 8'h43, 8'h63));
    tick(); out_ready = 1'b1; chk("t3_hold_c10", beat(), bx(1'b1, 8'h43, 8'h63));
    tick(); chk("t3_done_c11", {done, out_valid}, 2'b10);
    tick(); chk("t3_idle_c12", busy, 0);

    // zero-length line
    launch(8'd2, 1'b0);
    chk("t4_valid_c1", out_valid, 0);
    tick(); chk("t4_valid_c2", out_valid, 0);
    tick(); chk("t4_done_c3", {done, out_valid}, 2'b10);
    tick(); chk("t4_idle_c4", {busy, done}, 0);

    // address wrap
    launch(8'd3, 1'b0);
    tick(); tick(); chk("t5_addr_c3", mem_addr, 8'hFE);
    tick(); chk("t5_addr_c4", mem_addr, 8'hFF);
    tick(); chk("t5_addr_c5", mem_addr, 8'h00);
    chk("t5_beat_c5", beat(), bx(1'b0, 8'h51, 8'h71));
    tick(); chk("t5_beat_c6", beat(), bx(1'b0, 8'h52, 8'h72));
    tick(); chk("t5_beat_c7", beat(), bx(1'b1, 8'h53, 8'h73));
    tick(); chk("t5_done_c8", done, 1);
    tick();

    // abort after one beat, then restart with start and abort together
    launch(8'd1, 1'b0);
    tick(); tick(); tick(); tick();
    chk("t6_beat_c5", beat(), bx(1'b0, 8'h41, 8'h61));
    tick(); out_ready = 1'b0; abort = 1'b1;
    chk("t6_beat_c6", beat(), bx(1'b0, 8'h42, 8'h62));
    tick(); abort = 1'b0;
    chk("t6_abort_c7", {out_valid, busy, done}, 0);
    chk("t6_abort_addr", mem_addr, 8'hFF);
    tick(); chk("t6_nodone_c8", {done, out_valid}, 0);
    line = 8'd1; swap = 1'b0; start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    chk("t6_start_wins", busy, 1);
    tick(); tick(); tick(); tick();
    chk("t6_re_c5", beat(), bx(1'b0, 8'h41, 8'h61));
    tick(); chk("t6_re_c6", beat(), bx(1'b0, 8'h42, 8'h62));
    tick(); chk("t6_re_c7", beat(), bx(1'b1, 8'h43, 8'h63));
    tick(); chk("t6_re_done", done, 1);
    tick();

    // reset mid-line
    launch(8'd1, 1'b0);
    tick(); tick(); tick(); tick();
    chk("t7_beat_c5", beat(), bx(1'b0, 8'h41, 8'h61));
    rst = 1'b0;
    #1;
    chk("t7_rst_beat", beat(), 0);
    chk("t7_rst_state", {busy, done}, 0);
    chk("t7_rst_addr", mem_addr, 8'hFF);
    rst = 1'b1;
    tick(); chk("t7_after_rst", {busy, done, out_valid}, 0);
    launch(8'd1, 1'b0);
    tick(); tick(); tick(); tick();
    chk("t7_re_c5", beat(), bx(1'b0, 8'h41, 8'h61));
    tick(); chk("t7_re_c6", beat(), bx(1'b0, 8'h42, 8'h62));
    tick(); chk("t7_re_c7", beat(), bx(1'b1, 8'h43, 8'h63));
    tick(); chk("t7_re_done", done, 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
